// File: rtl/qft_stage_sequencer_pkg.sv
// Shared types and constants for the 3-qubit QFT stage sequencer.
// QFT_SKIP_SWAP_EN drops the final SWAP(q0,q2) stage (output left bit-reversed).
package qft_stage_sequencer_pkg;

  localparam int unsigned TOTAL_WIDTH = 16;

  localparam int unsigned QFT_NUM_AMPS = 8;
  localparam int unsigned STATE_W      = 2 * QFT_NUM_AMPS * TOTAL_WIDTH;

  localparam logic [2:0] STAGE_H_Q2       = 3'd0;
  localparam logic [2:0] STAGE_CP2_Q1Q2   = 3'd1;
  localparam logic [2:0] STAGE_CP4_Q0Q2   = 3'd2;
  localparam logic [2:0] STAGE_H_Q1       = 3'd3;
  localparam logic [2:0] STAGE_CP2_Q0Q1   = 3'd4;
  localparam logic [2:0] STAGE_H_Q0       = 3'd5;
  localparam logic [2:0] STAGE_SWAP_Q0Q2  = 3'd6;

`ifdef QFT_SKIP_SWAP_EN
  localparam int unsigned NUM_STAGES = 6;
`else
  localparam int unsigned NUM_STAGES = 7;
`endif

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StIssue = 2'd1,
    StDone  = 2'd2
  } seq_state_e;

endpackage

// File: rtl/qft_stage_sequencer_state_reg.sv
// 16-word complex state register, loadable from the input port or the gate network.
module qft_stage_sequencer_state_reg
  import qft_stage_sequencer_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  input  logic               load_in,
  input  logic               load_gate,
  input  logic [STATE_W-1:0] in_state,
  input  logic [STATE_W-1:0] gate_result,
  output logic [STATE_W-1:0] state_q
);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= '0;
    end else if (load_in) begin
      state_q <= in_state;
    end else if (load_gate) begin
      state_q <= gate_result;
    end
  end

endmodule

// File: rtl/qft_stage_sequencer.sv
// Steps the QFT state vector through the fixed gate order via an external gate network.
// Stage count depends on QFT_SKIP_SWAP_EN (see package).
module qft_stage_sequencer
  import qft_stage_sequencer_pkg::*;
#(
  parameter int unsigned GATE_LATENCY = 0
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [STATE_W-1:0] in_state,
  output logic [2:0]         gate_sel,
  output logic               gate_valid,
  output logic [STATE_W-1:0] gate_state,
  input  logic [STATE_W-1:0] gate_result,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [STATE_W-1:0] out_state,
  output logic               busy,
  output logic [2:0]         stage_idx
);

  localparam int unsigned CntW = (GATE_LATENCY > 0) ? $clog2(GATE_LATENCY + 1) : 1;
  localparam logic [CntW-1:0] LatLast   = CntW'(GATE_LATENCY);
  localparam logic [2:0]      LastStage = 3'(NUM_STAGES - 1);

  seq_state_e         st;
  logic [CntW-1:0]    cnt;
  logic [STATE_W-1:0] state_q;
  logic               load_in;
  logic               load_gate;

  assign load_in   = (st == StIdle) && in_valid;
  assign load_gate = (st == StIssue) && (cnt == LatLast);

  qft_stage_sequencer_state_reg u_state_reg (
    .clk        (clk),
    .rst        (rst),
    .load_in    (load_in),
    .load_gate  (load_gate),
    .in_state   (in_state),
    .gate_result(gate_result),
    .state_q    (state_q)
  );

  // The state register only changes on a gate capture, so both views stay stable per stage.
  assign gate_state = state_q;
  assign out_state  = state_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      st         <= StIdle;
      cnt        <= '0;
      stage_idx  <= 3'd0;
      gate_sel   <= 3'd0;
      gate_valid <= 1'b0;
      out_valid  <= 1'b0;
      busy       <= 1'b0;
      in_ready   <= 1'b1;
    end else begin
      case (st)
        StIdle: begin
          if (in_valid) begin
            st         <= StIssue;
            cnt        <= '0;
            stage_idx  <= 3'd0;
            gate_sel   <= STAGE_H_Q2;
            gate_valid <= 1'b1;
            busy       <= 1'b1;
            in_ready   <= 1'b0;
          end
        end
        StIssue: begin
          if (cnt == LatLast) begin
            cnt <= '0;
            if (stage_idx == LastStage) begin
              st         <= StDone;
              gate_valid <= 1'b0;
              gate_sel   <= 3'd0;
              out_valid  <= 1'b1;
            end else begin
              stage_idx <= stage_idx + 3'd1;
              gate_sel  <= stage_idx + 3'd1;
            end
          end else begin
            cnt <= cnt + CntW'(1);
          end
        end
        StDone: begin
          if (out_ready) begin
            st        <= StIdle;
            out_valid <= 1'b0;
            busy      <= 1'b0;
            in_ready  <= 1'b1;
          end
        end
        default: st <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_qft_stage_sequencer.sv
// Directed bench for qft_stage_sequencer: latency-0 and latency-2 instances on one clock.
module tb_qft_stage_sequencer;
  import qft_stage_sequencer_pkg::*;

  localparam int TW = TOTAL_WIDTH;
`ifdef QFT_SKIP_SWAP_EN
  localparam int NS = 6;
`else
  localparam int NS = 7;
`endif

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic               in_valid0, in_ready0, gate_valid0, out_valid0, out_ready0, busy0;
  logic [2:0]         gate_sel0, stage_idx0;
  logic [STATE_W-1:0] in_state0, gate_state0, gate_result0, out_state0;
  logic               in_valid2, in_ready2, gate_valid2, out_valid2, out_ready2, busy2;
  logic [2:0]         gate_sel2, stage_idx2;
  logic [STATE_W-1:0] in_state2, gate_state2, gate_result2, out_state2;
  logic               swap_mode;

  int checks = 0;
  int passed = 0;

  function automatic logic [STATE_W-1:0] set_amp(input logic [STATE_W-1:0] v, input int k,
                                                 input int re, input int im);
    logic [STATE_W-1:0] r;
    r = v;
    r[2*k*TW +: TW]     = TW'(re);
    r[(2*k+1)*TW +: TW] = TW'(im);
    return r;
  endfunction

  // Stage 6 swaps amp1<->amp4 and amp3<->amp6; everything else passes through.
  function automatic logic [STATE_W-1:0] swap_model(input logic [2:0] sel,
                                                    input logic [STATE_W-1:0] s);
    logic [STATE_W-1:0] r;
    r = s;
    if (sel == 3'd6) begin
      r[2*TW +: 2*TW]  = s[8*TW +: 2*TW];
      r[8*TW +: 2*TW]  = s[2*TW +: 2*TW];
      r[6*TW +: 2*TW]  = s[12*TW +: 2*TW];
      r[12*TW +: 2*TW] = s[6*TW +: 2*TW];
    end
    return r;
  endfunction

  // Each capture adds 1 to amp0.re, so the number of captures is visible in the result.
  function automatic logic [STATE_W-1:0] inc_model(input logic [STATE_W-1:0] s);
    logic [STATE_W-1:0] r;
    r = s;
    r[0 +: TW] = s[0 +: TW] + TW'(1);
    return r;
  endfunction

  assign gate_result0 = swap_mode ? swap_model(gate_sel0, gate_state0) : gate_state0;
  assign gate_result2 = inc_model(gate_state2);

  qft_stage_sequencer #(.GATE_LATENCY(0)) dut0 (
    .clk(clk), .rst(rst), .in_valid(in_valid0), .in_ready(in_ready0), .in_state(in_state0),
    .gate_sel(gate_sel0), .gate_valid(gate_valid0), .gate_state(gate_state0),
    .gate_result(gate_result0), .out_valid(out_valid0), .out_ready(out_ready0),
    .out_state(out_state0), .busy(busy0), .stage_idx(stage_idx0)
  );

  qft_stage_sequencer #(.GATE_LATENCY(2)) dut2 (
    .clk(clk), .rst(rst), .in_valid(in_valid2), .in_ready(in_ready2), .in_state(in_state2),
    .gate_sel(gate_sel2), .gate_valid(gate_valid2), .gate_state(gate_state2),
    .gate_result(gate_result2), .out_valid(out_valid2), .out_ready(out_ready2),
    .out_state(out_state2), .busy(busy2), .stage_idx(stage_idx2)
  );

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    checks++; if (in_ready0 !== 1'b1) $display("FAIL reset_in_ready got %b want 1", in_ready0); else passed++;
    checks++; if (out_valid0 !== 1'b0) $display("FAIL reset_out_valid got %b want 0", out_valid0); else passed++;
    checks++; if (gate_valid0 !== 1'b0) $display("FAIL reset_gate_valid got %b want 0", gate_valid0); else passed++;
    checks++; if (busy0 !== 1'b0) $display("FAIL reset_busy got %b want 0", busy0); else passed++;
    checks++; if (gate_sel0 !== 3'd0) $display("FAIL reset_gate_sel got %0d want 0", gate_sel0); else passed++;
    checks++; if (stage_idx0 !== 3'd0) $display("FAIL reset_stage_idx got %0d want 0", stage_idx0); else passed++;
    checks++; if (out_state0 !== '0) $display("FAIL reset_out_state got %h want 0", out_state0); else passed++;
    checks++; if (in_ready2 !== 1'b1) $display("FAIL reset_in_ready2 got %b want 1", in_ready2); else passed++;
  endtask

  task automatic test_pass_l0();
    logic [STATE_W-1:0] v;
    v = set_amp('0, 0, 16, 0);
    swap_mode = 1'b0;
    @(negedge clk); in_valid0 = 1'b1; in_state0 = v;
    @(negedge clk); in_valid0 = 1'b0; in_state0 = '0;
    for (int k = 1; k <= NS + 1; k++) begin
      if (k <= NS) begin
        checks++; if (gate_valid0 !== 1'b1) $display("FAIL pass_gate_valid k=%0d got %b want 1", k, gate_valid0); else passed++;
        checks++; if (gate_sel0 !== 3'(k-1)) $display("FAIL pass_gate_sel k=%0d got %0d want %0d", k, gate_sel0, k-1); else passed++;
        checks++; if (out_valid0 !== 1'b0) $display("FAIL pass_early_out k=%0d got %b want 0", k, out_valid0); else passed++;
        @(negedge clk);
      end else begin
        checks++; if (out_valid0 !== 1'b1) $display("FAIL pass_out_valid k=%0d got %b want 1", k, out_valid0); else passed++;
        checks++; if (gate_valid0 !== 1'b0) $display("FAIL pass_gate_idle got %b want 0", gate_valid0); else passed++;
      end
    end
    checks++; if (out_state0 !== v) $display("FAIL pass_out_state got %h want %h", out_state0, v); else passed++;
    out_ready0 = 1'b1;
    @(negedge clk); out_ready0 = 1'b0;
    checks++; if (out_valid0 !== 1'b0) $display("FAIL pass_out_drop got %b want 0", out_valid0); else passed++;
    checks++; if (in_ready0 !== 1'b1) $display("FAIL pass_in_ready got %b want 1", in_ready0); else passed++;
    checks++; if (busy0 !== 1'b0) $display("FAIL pass_busy got %b want 0", busy0); else passed++;
  endtask

  task automatic test_swap();
    logic [STATE_W-1:0] v, e;
    int n;
    v = set_amp(set_amp(set_amp(set_amp('0, 1, 8, 0), 4, -8, 0), 3, 0, 8), 6, 0, -8);
`ifdef QFT_SKIP_SWAP_EN
    e = v;
`else
    e = set_amp(set_amp(set_amp(set_amp('0, 1, -8, 0), 4, 8, 0), 3, 0, -8), 6, 0, 8);
`endif
    swap_mode = 1'b1;
    @(negedge clk); in_valid0 = 1'b1; in_state0 = v;
    @(negedge clk); in_valid0 = 1'b0;
    n = 0;
    while (out_valid0 !== 1'b1 && n < 40) begin
      checks++; if (gate_sel0 > 3'(NS-1)) $display("FAIL swap_stage_code got %0d want <=%0d", gate_sel0, NS-1); else passed++;
      @(negedge clk); n++;
    end
    checks++; if (n != NS) $display("FAIL swap_latency got %0d want %0d", n + 1, NS + 1); else passed++;
    checks++; if (out_state0 !== e) $display("FAIL swap_out_state got %h want %h", out_state0, e); else passed++;
    out_ready0 = 1'b1;
    @(negedge clk); out_ready0 = 1'b0; swap_mode = 1'b0;
  endtask

  task automatic test_latency2();
    logic [STATE_W-1:0] v, e;
    v = set_amp(set_amp('0, 0, 5, 0), 2, 3, -3);
    @(negedge clk); in_valid2 = 1'b1; in_state2 = v;
    @(negedge clk); in_valid2 = 1'b0; in_state2 = '0;
    for (int k = 1; k <= 3*NS + 1; k++) begin
      if (k <= 3*NS) begin
        e = set_amp(v, 0, 5 + (k-1)/3, 0);
        checks++; if (gate_sel2 !== 3'((k-1)/3)) $display("FAIL lat2_gate_sel k=%0d got %0d want %0d", k, gate_sel2, (k-1)/3); else passed++;
        checks++; if (gate_state2 !== e) $display("FAIL lat2_gate_state k=%0d got %h want %h", k, gate_state2, e); else passed++;
        checks++; if (out_valid2 !== 1'b0) $display("FAIL lat2_early_out k=%0d got %b want 0", k, out_valid2); else passed++;
        @(negedge clk);
      end else begin
        e = set_amp(v, 0, 5 + NS, 0);
        checks++; if (out_valid2 !== 1'b1) $display("FAIL lat2_out_valid k=%0d got %b want 1", k, out_valid2); else passed++;
        checks++; if (out_state2 !== e) $display("FAIL lat2_out_state got %h want %h", out_state2, e); else passed++;
      end
    end
    out_ready2 = 1'b1;
    @(negedge clk); out_ready2 = 1'b0;
    checks++; if (in_ready2 !== 1'b1) $display("FAIL lat2_in_ready got %b want 1", in_ready2); else passed++;
  endtask

  task automatic test_back_to_back();
    logic [STATE_W-1:0] a, b;
    int n;
    a = set_amp(set_amp('0, 5, 100, -7), 7, -1, 1);
    b = set_amp(set_amp('0, 2, -300, 42), 0, 9, 9);
    @(negedge clk); in_valid0 = 1'b1; in_state0 = a;
    @(negedge clk); in_valid0 = 1'b0;
    n = 0;
    while (out_valid0 !== 1'b1 && n < 40) begin @(negedge clk); n++; end
    checks++; if (out_valid0 !== 1'b1) $display("FAIL stall_timeout got %b want 1", out_valid0); else passed++;
    for (int i = 0; i < 5; i++) begin
      in_valid0 = (i % 2 == 0); in_state0 = b;
      @(negedge clk);
      checks++; if (out_valid0 !== 1'b1) $display("FAIL stall_out_valid i=%0d got %b want 1", i, out_valid0); else passed++;
      checks++; if (out_state0 !== a) $display("FAIL stall_out_state i=%0d got %h want %h", i, out_state0, a); else passed++;
      checks++; if (in_ready0 !== 1'b0) $display("FAIL stall_in_ready i=%0d got %b want 0", i, in_ready0); else passed++;
    end
    in_valid0 = 1'b0; out_ready0 = 1'b1;
    @(negedge clk); out_ready0 = 1'b0;
    checks++; if (in_ready0 !== 1'b1) $display("FAIL b2b_in_ready got %b want 1", in_ready0); else passed++;
    checks++; if (out_valid0 !== 1'b0) $display("FAIL b2b_out_drop got %b want 0", out_valid0); else passed++;
    in_valid0 = 1'b1; in_state0 = b;
    @(negedge clk); in_valid0 = 1'b0;
    checks++; if (gate_sel0 !== 3'd0 || gate_valid0 !== 1'b1) $display("FAIL b2b_start got sel=%0d gv=%b want sel=0 gv=1", gate_sel0, gate_valid0); else passed++;
    n = 0;
    while (out_valid0 !== 1'b1 && n < 40) begin @(negedge clk); n++; end
    checks++; if (n != NS) $display("FAIL b2b_latency got %0d want %0d", n + 1, NS + 1); else passed++;
    checks++; if (out_state0 !== b) $display("FAIL b2b_out_state got %h want %h", out_state0, b); else passed++;
    out_ready0 = 1'b1;
    @(negedge clk); out_ready0 = 1'b0;
  endtask

  task automatic test_reset_mid();
    logic [STATE_W-1:0] v;
    int n;
    logic seen;
    v = set_amp('0, 6, 77, -77);
    @(negedge clk); in_valid0 = 1'b1; in_state0 = v;
    @(negedge clk); in_valid0 = 1'b0;
    n = 0;
    while (stage_idx0 !== 3'd3 && n < 20) begin @(negedge clk); n++; end
    checks++; if (stage_idx0 !== 3'd3) $display("FAIL mid_reach_stage3 got %0d want 3", stage_idx0); else passed++;
    rst = 1'b1;
    @(negedge clk); rst = 1'b0;
    checks++; if (in_ready0 !== 1'b1) $display("FAIL mid_in_ready got %b want 1", in_ready0); else passed++;
    checks++; if (gate_valid0 !== 1'b0) $display("FAIL mid_gate_valid got %b want 0", gate_valid0); else passed++;
    checks++; if (gate_sel0 !== 3'd0) $display("FAIL mid_gate_sel got %0d want 0", gate_sel0); else passed++;
    checks++; if (stage_idx0 !== 3'd0) $display("FAIL mid_stage_idx got %0d want 0", stage_idx0); else passed++;
    checks++; if (busy0 !== 1'b0) $display("FAIL mid_busy got %b want 0", busy0); else passed++;
    checks++; if (out_state0 !== '0) $display("FAIL mid_out_state got %h want 0", out_state0); else passed++;
    seen = 1'b0;
    for (int i = 0; i < 10; i++) begin
      if (out_valid0 !== 1'b0) seen = 1'b1;
      @(negedge clk);
    end
    checks++; if (seen !== 1'b0) $display("FAIL mid_no_out_valid got %b want 0", seen); else passed++;
    in_valid0 = 1'b1; in_state0 = v;
    @(negedge clk); in_valid0 = 1'b0;
    for (int k = 1; k <= NS; k++) begin
      checks++; if (gate_sel0 !== 3'(k-1)) $display("FAIL mid_rerun_sel k=%0d got %0d want %0d", k, gate_sel0, k-1); else passed++;
      @(negedge clk);
    end
    checks++; if (out_valid0 !== 1'b1) $display("FAIL mid_rerun_out_valid got %b want 1", out_valid0); else passed++;
    checks++; if (out_state0 !== v) $display("FAIL mid_rerun_out_state got %h want %h", out_state0, v); else passed++;
    out_ready0 = 1'b1;
    @(negedge clk); out_ready0 = 1'b0;
  endtask

  initial begin
    rst = 1'b1; swap_mode = 1'b0;
    in_valid0 = 1'b0; in_state0 = '0; out_ready0 = 1'b0;
    in_valid2 = 1'b0; in_state2 = '0; out_ready2 = 1'b0;
    test_reset();
    test_pass_l0();
    test_swap();
    test_latency2();
    test_back_to_back();
    test_reset_mid();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
